// File: rtl/fifo_wr_arb_if.sv
`default_nettype none
// ============================================================================
// Module   : fifo_wr_arb_if
// Purpose  : Bundles the producer request bus, the FIFO write port, the FIFO
//            status flags and the arbiter observability outputs of
//            fifo_wr_arb into one interface.
// Ports    : req_valid/req_data      producers -> arbiter
//            req_ready               arbiter -> producers (one-hot grant)
//            data_in/wr_en           arbiter -> FIFO write port
//            full/almostfull/wr_ack/overflow   FIFO -> arbiter status
//            grant_id/wr_cnt/ovf_cnt/state     arbiter status outputs
// Modports : master - environment side (producers + FIFO model)
//            slave  - arbiter side
// Revision : 1.0  initial release
// ============================================================================
interface fifo_wr_arb_if #(
  parameter int FIFO_WIDTH = 16,
  parameter int NUM_REQ    = 4
);
  logic [NUM_REQ-1:0]            req_valid;
  logic [NUM_REQ*FIFO_WIDTH-1:0] req_data;
  logic [NUM_REQ-1:0]            req_ready;
  logic [FIFO_WIDTH-1:0]         data_in;
  logic                          wr_en;
  logic                          full;
  logic                          almostfull;
  logic                          wr_ack;
  logic                          overflow;
  logic [$clog2(NUM_REQ)-1:0]    grant_id;
  logic [15:0]                   wr_cnt;
  logic [7:0]                    ovf_cnt;
  logic [1:0]                    state;

  modport master (
    output req_valid, req_data, full, almostfull, wr_ack, overflow,
    input  req_ready, data_in, wr_en, grant_id, wr_cnt, ovf_cnt, state
  );

  modport slave (
    input  req_valid, req_data, full, almostfull, wr_ack, overflow,
    output req_ready, data_in, wr_en, grant_id, wr_cnt, ovf_cnt, state
  );
endinterface
`default_nettype wire

// File: rtl/fifo_wr_arb.sv
`default_nettype none
// ============================================================================
// Module   : fifo_wr_arb
// Purpose  : Round-robin write arbiter placing NUM_REQ producers onto a single
//            FIFO write port, one transfer per cycle. Tracks accepted writes
//            (wr_ack) and FIFO overflow events.
// Ports    : clk    - single clock, all state on the rising edge
//            rst_n  - asynchronous active-low reset
//            bus    - fifo_wr_arb_if.slave:
//                       req_valid/req_data in, req_ready out (combinational),
//                       data_in/wr_en out (registered),
//                       full/almostfull/wr_ack/overflow in,
//                       grant_id/wr_cnt/ovf_cnt/state out (registered)
// Revision : 1.0  initial release
// ============================================================================
module fifo_wr_arb #(
  parameter int FIFO_WIDTH = 16,
  parameter int NUM_REQ    = 4
) (
  input  wire logic     clk,
  input  wire logic     rst_n,
  fifo_wr_arb_if.slave  bus
);

  localparam int c_ID_W  = $clog2(NUM_REQ);
  // One extra bit so grant_id + offset (at most 2*NUM_REQ-1) never wraps.
  localparam int c_SUM_W = c_ID_W + 1;
  localparam logic [c_ID_W-1:0] c_LAST_ID = c_ID_W'(NUM_REQ - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_STALL = 2'd2
  } state_t;

  state_t                r_state;
  logic                  r_wr_en;
  logic [FIFO_WIDTH-1:0] r_data_in;
  logic [c_ID_W-1:0]     r_grant_id;
  logic [15:0]           r_wr_cnt;
  logic [7:0]            r_ovf_cnt;

  logic                  w_can_issue;
  logic                  w_any_valid;
  logic                  w_sel_found;
  logic [c_ID_W-1:0]     w_sel_id;
  logic [c_SUM_W-1:0]    w_cand;
  logic [NUM_REQ-1:0]    w_ready;
  logic                  w_xfer;
  logic [FIFO_WIDTH-1:0] w_sel_data;

  // The FIFO flags lag our own write by one cycle: when almostfull is seen
  // while a write is already landing, that write may be the one that fills
  // the FIFO, so hold off this cycle.
  assign w_can_issue = !bus.full && !(bus.almostfull && r_wr_en);
  assign w_any_valid = |bus.req_valid;

  // Round-robin search: scan offsets 1..NUM_REQ from the last grant, so the
  // last winner is checked last and a persistent requester cannot starve
  // the others.
  always_comb begin
    w_sel_found = 1'b0;
    w_sel_id    = r_grant_id;
    w_cand      = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      w_cand = {1'b0, r_grant_id} + c_SUM_W'(k);
      if (w_cand >= c_SUM_W'(NUM_REQ)) begin
        w_cand = w_cand - c_SUM_W'(NUM_REQ);
      end
      if (!w_sel_found && bus.req_valid[w_cand[c_ID_W-1:0]]) begin
        w_sel_found = 1'b1;
        w_sel_id    = w_cand[c_ID_W-1:0];
      end
    end
  end

  // Grant is gated by rst_n so no producer sees a handshake while reset is
  // held, independent of the register state.
  always_comb begin
    w_ready = '0;
    if (rst_n && w_can_issue && w_sel_found) begin
      w_ready[w_sel_id] = 1'b1;
    end
  end

  assign w_xfer     = |(bus.req_valid & w_ready);
  assign w_sel_data = bus.req_data[w_sel_id*FIFO_WIDTH +: FIFO_WIDTH];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= ST_IDLE;
      r_wr_en    <= 1'b0;
      r_data_in  <= '0;
      r_grant_id <= c_LAST_ID;
      r_wr_cnt   <= 16'd0;
      r_ovf_cnt  <= 8'd0;
    end else begin
      // Write port: one registered write per accepted handshake; data_in
      // keeps its last value on idle cycles.
      r_wr_en <= w_xfer;
      if (w_xfer) begin
        r_data_in  <= w_sel_data;
        r_grant_id <= w_sel_id;
      end

      if (bus.wr_ack) begin
        r_wr_cnt <= r_wr_cnt + 16'd1;
      end
      if (bus.overflow && (r_ovf_cnt != 8'hFF)) begin
        r_ovf_cnt <= r_ovf_cnt + 8'd1;
      end

      case (r_state)
        ST_IDLE: begin
          if (w_xfer) begin
            r_state <= ST_ISSUE;
          end else if (w_any_valid && !w_can_issue) begin
            r_state <= ST_STALL;
          end
        end
        ST_ISSUE: begin
          if (!w_any_valid) begin
            r_state <= ST_IDLE;
          end else if (!w_can_issue) begin
            r_state <= ST_STALL;
          end
        end
        ST_STALL: begin
          if (w_xfer) begin
            r_state <= ST_ISSUE;
          end else if (!w_any_valid) begin
            r_state <= ST_IDLE;
          end
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.req_ready = w_ready;
  assign bus.data_in   = r_data_in;
  assign bus.wr_en     = r_wr_en;
  assign bus.grant_id  = r_grant_id;
  assign bus.wr_cnt    = r_wr_cnt;
  assign bus.ovf_cnt   = r_ovf_cnt;
  assign bus.state     = r_state;

endmodule
`default_nettype wire

// File: tb/tb_fifo_wr_arb.sv
`default_nettype none
// ============================================================================
// Module   : tb_fifo_wr_arb
// Purpose  : Self-checking bench for fifo_wr_arb. A reference model predicts
//            grants, state and counters each cycle; predicted writes go into
//            a scoreboard queue that a separate monitor drains whenever the
//            DUT asserts wr_en.
// Revision : 1.0  initial release
// ============================================================================
module tb_fifo_wr_arb;
    localparam int FW = 16;
    localparam int NR = 4;

    logic clk;
    logic rst_n;

    fifo_wr_arb_if #(.FIFO_WIDTH(FW), .NUM_REQ(NR)) ifc ();

    fifo_wr_arb #(.FIFO_WIDTH(FW), .NUM_REQ(NR)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (ifc)
    );

    typedef struct {
        int            id;
        logic [FW-1:0] data;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_pass   = 0;

    int m_last;
    int m_state;
    int m_grant;
    bit m_wr_en;
    int m_wr_cnt;
    int m_ovf_cnt;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic void check(string name, bit ok);
        n_checks++;
        if (ok) n_pass++;
        else $display("FAIL %s at %0t", name, $time);
    endfunction

    task automatic model_reset();
        m_last    = NR - 1;
        m_state   = 0;
        m_grant   = -1;
        m_wr_en   = 1'b0;
        m_wr_cnt  = 0;
        m_ovf_cnt = 0;
        exp_q.delete();
    endtask

    task automatic set_prod(int i, bit v, logic [FW-1:0] d);
        ifc.req_valid[i]         = v;
        ifc.req_data[i*FW +: FW] = d;
    endtask

    task automatic step();
        bit   can;
        int   idx;
        exp_t e;
        @(negedge clk);
        can     = !ifc.full && !(ifc.almostfull && m_wr_en);
        m_grant = -1;
        if (can) begin
            for (int k = 1; k <= NR; k++) begin
                idx = (m_last + k) % NR;
                if (m_grant < 0 && ifc.req_valid[idx]) m_grant = idx;
            end
        end
        check("req_ready", ifc.req_ready === NR'((m_grant >= 0) ? (1 << m_grant) : 0));
        check("state", ifc.state === 2'(m_state));
        check("wr_cnt", ifc.wr_cnt === 16'(m_wr_cnt));
        check("ovf_cnt", ifc.ovf_cnt === 8'(m_ovf_cnt));
        if (m_grant >= 0) begin
            e.id   = m_grant;
            e.data = ifc.req_data[m_grant*FW +: FW];
            exp_q.push_back(e);
            m_last = m_grant;
        end
        m_state = (ifc.req_valid == '0) ? 0 : ((m_grant >= 0) ? 1 : 2);
        m_wr_en = (m_grant >= 0);
        if (ifc.wr_ack) m_wr_cnt = (m_wr_cnt + 1) % 65536;
        if (ifc.overflow && m_ovf_cnt < 255) m_ovf_cnt++;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        #2 rst_n = 1'b0;
        #1;
        check("rst_wr_en", ifc.wr_en === 1'b0);
        check("rst_req_ready", ifc.req_ready === '0);
        check("rst_state", ifc.state === 2'd0);
        check("rst_grant_id", ifc.grant_id === 2'(NR - 1));
        check("rst_data_in", ifc.data_in === '0);
        model_reset();
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    task automatic rnd_status();
        ifc.full       = ($urandom_range(0, 4) == 0);
        ifc.almostfull = ($urandom_range(0, 2) == 0);
        ifc.wr_ack     = ($urandom_range(0, 1) == 1);
        ifc.overflow   = ($urandom_range(0, 3) == 0);
    endtask

    task automatic rnd_producers();
        for (int i = 0; i < NR; i++) begin
            if (m_grant == i) begin
                if ($urandom_range(0, 2) == 0) ifc.req_valid[i] = 1'b0;
                else ifc.req_data[i*FW +: FW] = FW'($urandom);
            end else if (!ifc.req_valid[i] && $urandom_range(0, 1) == 1) begin
                set_prod(i, 1'b1, FW'($urandom));
            end
        end
    endtask

    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst_n === 1'b1 && ifc.wr_en === 1'b1) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_wr_en", ifc.wr_en === 1'b0);
                end else begin
                    e = exp_q.pop_front();
                    check("data_in", ifc.data_in === e.data);
                    check("grant_id", ifc.grant_id === 2'(e.id));
                end
            end
        end
    end

    initial begin
        rst_n          = 1'b1;
        ifc.req_valid  = '0;
        ifc.req_data   = '0;
        ifc.full       = 1'b0;
        ifc.almostfull = 1'b0;
        ifc.wr_ack     = 1'b0;
        ifc.overflow   = 1'b0;
        model_reset();
        for (int i = 0; i < NR; i++) set_prod(i, 1'b1, FW'(16'h1000 + i));
        #1 rst_n = 1'b0;
        #2;
        check("init_wr_en", ifc.wr_en === 1'b0);
        check("init_data_in", ifc.data_in === '0);
        check("init_grant_id", ifc.grant_id === 2'(NR - 1));
        check("init_wr_cnt", ifc.wr_cnt === 16'd0);
        check("init_ovf_cnt", ifc.ovf_cnt === 8'd0);
        check("init_state", ifc.state === 2'd0);
        check("init_req_ready", ifc.req_ready === '0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;

        for (int k = 0; k < 8; k++) begin
            step();
            check("rr_grant_id", ifc.grant_id === 2'(k % NR));
            check("rr_wr_en", ifc.wr_en === 1'b1);
            if (m_grant >= 0) ifc.req_data[m_grant*FW +: FW] = FW'($urandom);
        end
        ifc.req_valid = '0;
        step();
        step();

        set_prod(2, 1'b1, 16'hA5A5);
        #1;
        check("p2_req_ready", ifc.req_ready === 4'b0100);
        step();
        check("p2_wr_en", ifc.wr_en === 1'b1);
        check("p2_data_in", ifc.data_in === 16'hA5A5);
        check("p2_state", ifc.state === 2'd1);
        set_prod(2, 1'b0, '0);
        step();
        step();

        set_prod(1, 1'b1, 16'h1234);
        ifc.full = 1'b1;
        for (int k = 0; k < 10; k++) begin
            step();
            check("full_ready1", ifc.req_ready[1] === 1'b0);
            check("full_wr_en", ifc.wr_en === 1'b0);
            check("full_state", ifc.state === 2'd2);
        end
        ifc.full = 1'b0;
        step();
        check("unfull_wr_en", ifc.wr_en === 1'b1);
        check("unfull_data_in", ifc.data_in === 16'h1234);
        check("unfull_grant_id", ifc.grant_id === 2'd1);
        set_prod(1, 1'b0, '0);
        step();
        check("unfull_single_write", ifc.wr_en === 1'b0);
        step();

        set_prod(3, 1'b1, 16'h3333);
        step();
        check("af_grant_id", ifc.grant_id === 2'd3);
        check("af_wr_en", ifc.wr_en === 1'b1);
        set_prod(3, 1'b0, '0);
        set_prod(0, 1'b1, 16'h0A0A);
        set_prod(2, 1'b1, 16'h2B2B);
        ifc.almostfull = 1'b1;
        step();
        check("af_state", ifc.state === 2'd2);
        check("af_no_write", ifc.wr_en === 1'b0);
        ifc.almostfull = 1'b0;
        ifc.full       = 1'b1;
        repeat (3) step();
        check("af_full_wr_en", ifc.wr_en === 1'b0);
        check("af_full_state", ifc.state === 2'd2);
        ifc.full = 1'b0;
        step();
        check("resume_grant_id", ifc.grant_id === 2'd0);
        set_prod(0, 1'b0, '0);
        step();
        check("resume_next_grant", ifc.grant_id === 2'd2);
        set_prod(2, 1'b0, '0);
        step();
        step();

        for (int k = 0; k < 1500; k++) begin
            rnd_status();
            step();
            rnd_producers();
        end

        ifc.full       = 1'b0;
        ifc.almostfull = 1'b0;
        ifc.wr_ack     = 1'b0;
        ifc.overflow   = 1'b0;
        for (int i = 0; i < NR; i++) set_prod(i, 1'b1, FW'($urandom));
        repeat (3) step();
        do_reset();
        step();
        check("post_rst_grant_id", ifc.grant_id === 2'd0);
        ifc.req_valid = '0;
        step();
        step();

        do_reset();
        for (int k = 0; k < 300; k++) begin
            ifc.overflow = 1'b1;
            ifc.wr_ack   = (k < 3);
            step();
        end
        ifc.overflow = 1'b0;
        ifc.wr_ack   = 1'b0;
        step();
        check("final_wr_cnt", ifc.wr_cnt === 16'd3);
        check("final_ovf_cnt", ifc.ovf_cnt === 8'd255);

        step();
        step();
        check("queue_drained", exp_q.size() === 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/fifo_wr_arb.md
FIFO_WR_ARB -- requirements
Module: fifo_wr_arb

Parameters
REQ-001 SHALL have parameter FIFO_WIDTH, default 16, FIFO data width.
REQ-002 SHALL have parameter NUM_REQ, default 4, number of producers (2..8).

Interface
REQ-003 SHALL have clk  input  1  single clock; all state on rising edge.
REQ-004 SHALL have rst_n  input  1  reset; asynchronous, active-low.
REQ-005 SHALL have req_valid  input  NUM_REQ  per-producer write request.
REQ-006 SHALL have req_data  input  NUM_REQ*FIFO_WIDTH  producer i data at bits [i*FIFO_WIDTH +: FIFO_WIDTH].
REQ-007 SHALL have req_ready  output  NUM_REQ  one-hot-or-zero grant; combinational.
REQ-008 SHALL have data_in  output  FIFO_WIDTH  to FIFO write data; registered.
REQ-009 SHALL have wr_en  output  1  to FIFO write enable; registered.
REQ-010 SHALL have full, almostfull, wr_ack, overflow  input  1 each  FIFO status.
REQ-011 SHALL have grant_id  output  $clog2(NUM_REQ)  index of last accepted producer; registered.
REQ-012 SHALL have wr_cnt  output  16  count of wr_ack pulses; wraps at 65535->0.
REQ-013 SHALL have ovf_cnt  output  8  count of overflow pulses; saturates at 255.
REQ-014 SHALL have state  output  2  FSM state: IDLE=0, ISSUE=1, STALL=2.

Function
REQ-015 SHALL compute can_issue = !full && !(almostfull && wr_en), guarding the one-cycle status lag.
REQ-016 SHALL, when can_issue and any req_valid, assert req_ready for exactly one valid producer, chosen round-robin starting at (grant_id+1) mod NUM_REQ.
REQ-017 SHALL keep req_ready all-zero when can_issue=0 or no req_valid.
REQ-018 SHALL treat req_valid[i] && req_ready[i] as a transfer; next edge: wr_en=1, data_in=req_data[i], grant_id=i.
REQ-019 SHALL drive wr_en=0 on the edge after any cycle without a transfer; data_in holds its last value.
REQ-020 SHALL sustain one transfer per cycle; back-to-back grants rotate even if the same producer stays valid.
REQ-021 SHALL require producers to hold req_valid and req_data stable until transfer; a producer never waits more than NUM_REQ-1 transfers.
REQ-022 SHALL move IDLE->ISSUE on a transfer; IDLE->STALL when any req_valid and can_issue=0.
REQ-023 SHALL move ISSUE->IDLE when no req_valid; ISSUE->STALL when any req_valid and can_issue=0; otherwise stay ISSUE.
REQ-024 SHALL move STALL->ISSUE on a transfer; STALL->IDLE when no req_valid; otherwise stay STALL.
REQ-025 SHALL increment wr_cnt by 1 on each cycle wr_ack=1.
REQ-026 SHALL increment ovf_cnt by 1 on each cycle overflow=1, holding at 255.
REQ-027 SHALL ignore req_data of non-granted producers; simultaneous valid from all producers yields exactly one transfer.

Reset
REQ-028 SHALL, on rst_n low, immediately set wr_en=0, data_in=0, grant_id=NUM_REQ-1 (so producer 0 wins first), wr_cnt=0, ovf_cnt=0, state=IDLE.
REQ-029 SHALL force req_ready=0 while rst_n is low.
REQ-030 SHALL discard any transfer in flight when reset asserts mid-operation; no wr_en pulse follows reset release without a new transfer.

Verification
REQ-031 SHALL cover: all 4 req_valid=1, FIFO empty, 8 cycles -> req_ready order 0,1,2,3,0,1,2,3; wr_en=1 each following cycle; grant_id matches.
REQ-032 SHALL cover: only producer 2 valid with data 0xA5A5 -> req_ready=0100 same cycle, next edge wr_en=1, data_in=0xA5A5, state=ISSUE.
REQ-033 SHALL cover: almostfull=1 while wr_en=1 -> req_ready=0 that cycle, state=STALL; full=1 held -> no grant; full drops -> grant resumes at next round-robin index.
REQ-034 SHALL cover: 3 wr_ack pulses and 300 overflow pulses -> wr_cnt=3, ovf_cnt=255.
REQ-035 SHALL cover: rst_n low mid-burst between edges -> wr_en=0, req_ready=0, state=IDLE immediately; after release first grant goes to producer 0.
REQ-036 SHALL cover: producer 1 valid, req_data[1] stable, FIFO full 10 cycles -> req_ready[1]=0 throughout, no wr_en, state=STALL; exactly one write after full drops.
